// File: rtl/counter_seq_pkg.sv
// Shared types and helpers for the counter sequencer: FSM state encoding and
// the run-rate period calculation.
package counter_seq_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Run-mode step period for a given rate select; never less than one cycle.
    function automatic int unsigned rate_period(input int unsigned base, input logic [1:0] rate);
        int unsigned p;
        p = base >> rate;
        return (p == 0) ? 1 : p;
    endfunction

endpackage

// File: rtl/counter_seq_if.sv
// Board-side bundle of the counter sequencer: raw keys and switches in,
// counter control strobes out.
interface counter_seq_if #(
    parameter int WIDTH = 4
);
    logic             key_load_n;
    logic             key_step_n;
    logic             key_run_n;
    logic [WIDTH-1:0] sw_data;
    logic [1:0]       sw_rate;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_data;
    logic             ctr_en;
    logic             running;

    modport master (
        output key_load_n, key_step_n, key_run_n, sw_data, sw_rate,
        input  ctr_load, ctr_data, ctr_en, running
    );

    modport slave (
        input  key_load_n, key_step_n, key_run_n, sw_data, sw_rate,
        output ctr_load, ctr_data, ctr_en, running
    );
endinterface

// File: rtl/key_debounce.sv
// One push-button channel: 2-FF synchroniser, level debounce, and a one-cycle
// pulse on each accepted press (released -> pressed).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // NOTE: non-blocking assignments so every register samples the pre-edge
    // value; blocking here would collapse the synchroniser into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Controller for the loadable up-counter: debounced key events drive a
// STOP/RUN sequencer that issues registered load and count-enable strobes.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int          WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned TICK_DIV        = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    counter_seq_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);

    logic load_ev;
    logic step_ev;
    logic run_ev;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key_load_n),
        .press (load_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key_step_n),
        .press (step_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key_run_n),
        .press (run_ev)
    );

    seq_state_e       state_q,  state_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [1:0]       rate_q,   rate_d;
    logic             load_q,   load_d;
    logic             en_q,     en_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [PW-1:0]    term;

    // Rate select is only re-sampled at a wrap, so the terminal count is stable within a period.
    assign term = PW'(rate_period(TICK_DIV, rate_q) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STOP;
            presc_q <= '0;
            rate_q  <= '0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rate_q  <= rate_d;
            load_q  <= load_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rate_d  = rate_q;
        load_d  = 1'b0;
        en_d    = 1'b0;
        data_d  = data_q;

        // The if/else chain is the event priority: lower-priority events are dropped.
        if (load_ev) begin
            load_d  = 1'b1;
            data_d  = bus.sw_data;
            state_d = STOP;
            presc_d = '0;
        end else if (run_ev) begin
            presc_d = '0;
            rate_d  = bus.sw_rate;
            state_d = (state_q == STOP) ? RUN : STOP;
        end else if (step_ev && (state_q == STOP)) begin
            en_d = 1'b1;
        end else if (state_q == RUN) begin
            if (presc_q == term) begin
                en_d    = 1'b1;
                presc_d = '0;
                rate_d  = bus.sw_rate;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    assign bus.ctr_load = load_q;
    assign bus.ctr_en   = en_q;
    assign bus.ctr_data = data_q;
    assign bus.running  = (state_q == RUN);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with short debounce/tick settings;
// strobe timing is predicted from key-press times and run-rate arithmetic.
module tb_counter_sequencer;
    localparam int W   = 4;
    localparam int D   = 4;
    localparam int TD  = 8;
    localparam int LAT = 2 + D + 1;  // key low -> strobe visible
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    counter_seq_if #(.WIDTH(W)) bus ();

    counter_sequencer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .TICK_DIV        (TD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int load_t[$];
    int load_v[$];
    int en_t[$];
    int exp_en[$];
    int overlap = 0;

    always @(negedge clk) begin
        if (bus.ctr_load) begin
            load_t.push_back(cyc);
            load_v.push_back(int'(bus.ctr_data));
        end
        if (bus.ctr_en) en_t.push_back(cyc);
        if (bus.ctr_load && bus.ctr_en) overlap++;
    end

    int tests = 0;
    int fails = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic clear_log();
        load_t.delete();
        load_v.delete();
        en_t.delete();
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       bus.key_load_n = v;
            1:       bus.key_step_n = v;
            default: bus.key_run_n  = v;
        endcase
    endtask

    task automatic press(input int k, input int hold, output int t0);
        set_key(k, 1'b0);
        t0 = cyc;
        step(hold);
        set_key(k, 1'b1);
    endtask

    function automatic int period(input int r);
        int p;
        p = TD >> r;
        return (p < 1) ? 1 : p;
    endfunction

    // Expected run ticks: first one period after entry, rate re-read at each tick, none at/after stop_edge.
    function automatic void model_ticks(input int entry, input int stop_edge, input int rate0,
                                        input int t_change, input int rate1);
        int r;
        int t;
        exp_en.delete();
        r = rate0;
        t = entry + period(r);
        while (t < stop_edge) begin
            exp_en.push_back(t);
            r = (t > t_change) ? rate1 : rate0;
            t += period(r);
        end
    endfunction

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int first_or_neg(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic test_reset();
        logic [W+2:0] outs;
        step(1);
        outs = {bus.ctr_load, bus.ctr_en, bus.running, bus.ctr_data};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected 0", outs);
        end
        rst = 1'b0;
        clear_log();
        step(20);
        tests++;
        if (load_t.size() + en_t.size() != 0) begin
            fails++;
            $display("FAIL reset_release_strobes: got %0d strobes, expected 0", load_t.size() + en_t.size());
        end
    endtask

    task automatic test_load();
        int t0;
        clear_log();
        bus.sw_data = 4'hA;
        press(0, 10, t0);
        step(10);
        tests++;
        if (load_t.size() != 1) begin
            fails++;
            $display("FAIL load_count: got %0d, expected 1", load_t.size());
        end
        tests++;
        if (first_or_neg(load_t) != t0 + LAT) begin
            fails++;
            $display("FAIL load_time: got %0d, expected %0d", first_or_neg(load_t), t0 + LAT);
        end
        tests++;
        if (first_or_neg(load_v) != 10) begin
            fails++;
            $display("FAIL load_data: got %0d, expected 10", first_or_neg(load_v));
        end
        tests++;
        if (en_t.size() != 0) begin
            fails++;
            $display("FAIL load_no_en: got %0d, expected 0", en_t.size());
        end
        tests++;
        if (bus.ctr_data !== 4'hA || bus.running !== 1'b0) begin
            fails++;
            $display("FAIL load_hold: got data %h running %b, expected a 0", bus.ctr_data, bus.running);
        end
    endtask

    task automatic test_bounce();
        int tf;
        clear_log();
        for (int i = 0; i < 6; i++) begin
            set_key(1, (i % 2 == 0) ? 1'b0 : 1'b1);
            step(2);
        end
        set_key(1, 1'b0);
        tf = cyc;
        step(10);
        set_key(1, 1'b1);
        step(10);
        tests++;
        if (en_t.size() != 1) begin
            fails++;
            $display("FAIL bounce_count: got %0d, expected 1", en_t.size());
        end
        tests++;
        if (first_or_neg(en_t) != tf + LAT) begin
            fails++;
            $display("FAIL bounce_time: got %0d, expected %0d", first_or_neg(en_t), tf + LAT);
        end
        tests++;
        if (load_t.size() != 0) begin
            fails++;
            $display("FAIL bounce_no_load: got %0d, expected 0", load_t.size());
        end
    endtask

    task automatic test_run_rates();
        int t0, t1, entry, tc, r1;
        clear_log();
        bus.sw_rate = 2'd0;
        press(2, 6, t0);
        entry = t0 + LAT;
        wait_until(entry + 1);
        tests++;
        if (bus.running !== 1'b1) begin
            fails++;
            $display("FAIL run_running: got %b, expected 1", bus.running);
        end
        tc = entry + $urandom_range(12, 30);
        wait_until(tc);
        r1 = $urandom_range(1, 3);
        bus.sw_rate = 2'(r1);
        wait_until(tc + $urandom_range(10, 20));
        press(2, 6, t1);
        step(12);
        tests++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL run_stopped: got %b, expected 0", bus.running);
        end
        model_ticks(entry, t1 + LAT, 0, tc, r1);
        tests++;
        if (en_t.size() != exp_en.size()) begin
            fails++;
            $display("FAIL run_tick_count: got %0d, expected %0d", en_t.size(), exp_en.size());
        end
        tests++;
        if (!same_q(en_t, exp_en)) begin
            fails++;
            $display("FAIL run_tick_times: got first %0d, expected first %0d (rate %0d)",
                     first_or_neg(en_t), first_or_neg(exp_en), r1);
        end
    endtask

    task automatic test_priority();
        int t0, tr, ts, tl, entry, r, d, d2;
        clear_log();
        d = $urandom_range(1, 15);
        bus.sw_data = 4'(d);
        set_key(0, 1'b0);
        set_key(2, 1'b0);
        t0 = cyc;
        step(6);
        set_key(0, 1'b1);
        set_key(2, 1'b1);
        step(12);
        tests++;
        if (load_t.size() != 1 || first_or_neg(load_t) != t0 + LAT || first_or_neg(load_v) != d) begin
            fails++;
            $display("FAIL prio_load_over_run: got %0d pulses t=%0d v=%0d, expected 1 t=%0d v=%0d",
                     load_t.size(), first_or_neg(load_t), first_or_neg(load_v), t0 + LAT, d);
        end
        tests++;
        if (bus.running !== 1'b0 || en_t.size() != 0) begin
            fails++;
            $display("FAIL prio_stays_stop: got running %b en %0d, expected 0 0", bus.running, en_t.size());
        end

        clear_log();
        r = $urandom_range(0, 3);
        bus.sw_rate = 2'(r);
        press(2, 6, tr);
        entry = tr + LAT;
        wait_until(entry + $urandom_range(3, 10));
        press(1, 6, ts);
        wait_until(ts + $urandom_range(8, 16));
        d2 = $urandom_range(1, 15);
        bus.sw_data = 4'(d2);
        press(0, 6, tl);
        step(12);
        model_ticks(entry, tl + LAT, r, NEVER, r);
        tests++;
        if (!same_q(en_t, exp_en)) begin
            fails++;
            $display("FAIL prio_step_ignored_in_run: got %0d ticks, expected %0d (rate %0d)",
                     en_t.size(), exp_en.size(), r);
        end
        tests++;
        if (load_t.size() != 1 || first_or_neg(load_t) != tl + LAT || first_or_neg(load_v) != d2) begin
            fails++;
            $display("FAIL prio_load_in_run: got %0d pulses t=%0d v=%0d, expected 1 t=%0d v=%0d",
                     load_t.size(), first_or_neg(load_t), first_or_neg(load_v), tl + LAT, d2);
        end
        tests++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL prio_load_stops: got %b, expected 0", bus.running);
        end
    endtask

    task automatic test_collision();
        int tr, tl, entry, r, p, k, tick, d;
        clear_log();
        r = $urandom_range(0, 3);
        p = period(r);
        bus.sw_rate = 2'(r);
        press(2, 6, tr);
        entry = tr + LAT;
        k = (TD + p - 1) / p + $urandom_range(0, 2);
        tick = entry + p * k;
        wait_until(tick - LAT);
        d = $urandom_range(1, 15);
        bus.sw_data = 4'(d);
        press(0, 6, tl);
        step(12);
        tests++;
        if (load_t.size() != 1 || first_or_neg(load_t) != tl + LAT || first_or_neg(load_v) != d) begin
            fails++;
            $display("FAIL collide_load: got %0d pulses t=%0d v=%0d, expected 1 t=%0d v=%0d",
                     load_t.size(), first_or_neg(load_t), first_or_neg(load_v), tl + LAT, d);
        end
        model_ticks(entry, tl + LAT, r, NEVER, r);
        tests++;
        if (!same_q(en_t, exp_en)) begin
            fails++;
            $display("FAIL collide_tick_suppressed: got %0d ticks, expected %0d (tick %0d)",
                     en_t.size(), exp_en.size(), tick);
        end
        tests++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL collide_stop: got %b, expected 0", bus.running);
        end
    endtask

    task automatic test_reset_mid();
        int tr;
        logic [W+2:0] outs;
        clear_log();
        bus.sw_rate = 2'd0;
        press(2, 6, tr);
        wait_until(tr + LAT + $urandom_range(3, 12));
        tests++;
        if (bus.running !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre_running: got %b, expected 1", bus.running);
        end
        set_key(0, 1'b0);
        step($urandom_range(1, 4));
        #2;
        rst = 1'b1;
        #1;
        outs = {bus.ctr_load, bus.ctr_en, bus.running, bus.ctr_data};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL midrst_async: got %b, expected 0", outs);
        end
        set_key(0, 1'b1);
        clear_log();
        step(3);
        #2;
        rst = 1'b0;
        step(20);
        tests++;
        if (load_t.size() + en_t.size() != 0) begin
            fails++;
            $display("FAIL midrst_no_strobe: got %0d strobes, expected 0", load_t.size() + en_t.size());
        end
        tests++;
        if (bus.running !== 1'b0) begin
            fails++;
            $display("FAIL midrst_state: got running %b, expected 0", bus.running);
        end
    endtask

    task automatic test_back_to_back();
        int exp_lt[$];
        int exp_lv[$];
        int exp_et[$];
        int k, hold, d, t0;
        clear_log();
        for (int i = 0; i < 10; i++) begin
            k = $urandom_range(0, 1);
            hold = (i == 0) ? D - 1 : (i == 1) ? D : $urandom_range(1, 8);
            d = $urandom_range(0, 15);
            bus.sw_data = 4'(d);
            press(k, hold, t0);
            if (hold >= D) begin
                if (k == 0) begin
                    exp_lt.push_back(t0 + LAT);
                    exp_lv.push_back(d);
                end else begin
                    exp_et.push_back(t0 + LAT);
                end
            end
            step($urandom_range(7, 10));
        end
        step(12);
        tests++;
        if (!same_q(load_t, exp_lt)) begin
            fails++;
            $display("FAIL b2b_load_times: got %0d pulses, expected %0d", load_t.size(), exp_lt.size());
        end
        tests++;
        if (!same_q(load_v, exp_lv)) begin
            fails++;
            $display("FAIL b2b_load_data: got first %0d, expected first %0d", first_or_neg(load_v), first_or_neg(exp_lv));
        end
        tests++;
        if (!same_q(en_t, exp_et)) begin
            fails++;
            $display("FAIL b2b_step_times: got %0d pulses, expected %0d", en_t.size(), exp_et.size());
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.key_load_n = 1'b1;
        bus.key_step_n = 1'b1;
        bus.key_run_n  = 1'b1;
        bus.sw_data    = '0;
        bus.sw_rate    = '0;
        step(2);

        test_reset();
        test_load();
        test_bounce();
        test_run_rates();
        test_priority();
        test_collision();
        test_reset_mid();
        test_back_to_back();

        tests++;
        if (overlap != 0) begin
            fails++;
            $display("FAIL load_en_overlap: got %0d cycles, expected 0", overlap);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
